// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM sequencing controller: FSM encoding,
// default address/size widths and the systolic mesh geometry.
package gemm_pkg;

    localparam int DefAddrWidth     = 12;
    localparam int DefSizeAddrWidth = 8;

    localparam int meshRow  = 4;
    localparam int meshCol  = 4;
    localparam int tileSize = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } gemm_state_e;

endpackage

// File: rtl/gemm_ctrl_counter.sv
// Loop index counter with a limit latched at load time and a
// combinational terminal-count flag; wraps to zero when advanced at the limit.
module gemm_ctrl_counter
    import gemm_pkg::*;
#(
    parameter int Width = DefSizeAddrWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load,
    input  logic [Width-1:0] size,
    input  logic             clr,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic             last
);

    logic [Width-1:0] limit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
            limit <= '0;
        end else if (load) begin
            limit <= size - Width'(1);
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + Width'(1);
        end
    end

    assign last = (count == limit);

endmodule

// File: rtl/gemm_ctrl.sv
// GEMM tile sequencer: walks (m, n, k) with k innermost, drives SRAM A/B
// read addresses, the one-cycle-delayed mesh flags and the C write strobe.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for start_i; sizes latched on acceptance
//  ST_RUN   | one (m,n,k) issue per cycle, A/B addresses valid
//  ST_DRAIN | issues finished, waiting for the final C write to retire
//  ST_DONE  | one-cycle done_o pulse, then back to idle
module gemm_ctrl
    import gemm_pkg::*;
#(
    parameter int AddrWidth     = DefAddrWidth,
    parameter int SizeAddrWidth = DefSizeAddrWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mac_valid_o,
    output logic                     mac_first_o,
    output logic                     mac_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    gemm_state_e state, state_next;

    logic                     size_zero;
    logic                     load;
    logic                     run;
    logic                     tile_end;
    logic                     row_end;
    logic                     final_issue;

    logic [SizeAddrWidth-1:0] m_cnt, n_cnt, k_cnt;
    logic                     m_last, n_last, k_last;

    logic [AddrWidth-1:0]     k_step;
    logic [AddrWidth-1:0]     a_base;
    logic [AddrWidth-1:0]     b_base;
    logic [AddrWidth-1:0]     c_tile;
    logic [AddrWidth-1:0]     c_pipe;

    logic                     unused_cnt;

    assign size_zero   = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
    assign load        = (state == ST_IDLE) && start_i && !size_zero;
    assign run         = (state == ST_RUN);
    assign tile_end    = run && k_last;
    assign row_end     = tile_end && n_last;
    assign final_issue = row_end && m_last;

    // m and n only matter through their terminal-count flags.
    assign unused_cnt = ^{m_cnt, n_cnt};

    gemm_ctrl_counter #(.Width(SizeAddrWidth)) u_cnt_m (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load   (load),
        .size   (M_size_i),
        .clr    (!run),
        .en     (row_end),
        .count  (m_cnt),
        .last   (m_last)
    );

    gemm_ctrl_counter #(.Width(SizeAddrWidth)) u_cnt_n (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load   (load),
        .size   (N_size_i),
        .clr    (!run),
        .en     (tile_end),
        .count  (n_cnt),
        .last   (n_last)
    );

    gemm_ctrl_counter #(.Width(SizeAddrWidth)) u_cnt_k (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load   (load),
        .size   (K_size_i),
        .clr    (!run),
        .en     (run),
        .count  (k_cnt),
        .last   (k_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = size_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy_o = 1'b1;
                if (final_issue) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                // Last write is on the bus once nothing further is in the read pipe.
                if (sram_c_we_o && !mac_valid_o) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Running bases replace m*K and n*K; C is simply the tile ordinal.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_step <= '0;
            a_base <= '0;
            b_base <= '0;
            c_tile <= '0;
        end else if (load) begin
            k_step <= AddrWidth'(K_size_i);
            a_base <= '0;
            b_base <= '0;
            c_tile <= '0;
        end else if (run) begin
            if (row_end) begin
                a_base <= a_base + k_step;
                b_base <= '0;
            end else if (tile_end) begin
                b_base <= b_base + k_step;
            end
            if (tile_end) begin
                c_tile <= c_tile + AddrWidth'(1);
            end
        end
    end

    assign sram_a_addr_o = run ? a_base + AddrWidth'(k_cnt) : '0;
    assign sram_b_addr_o = run ? b_base + AddrWidth'(k_cnt) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mac_valid_o   <= 1'b0;
            mac_first_o   <= 1'b0;
            mac_last_o    <= 1'b0;
            c_pipe        <= '0;
            sram_c_we_o   <= 1'b0;
            sram_c_addr_o <= '0;
        end else begin
            mac_valid_o   <= run;
            mac_first_o   <= run && (k_cnt == '0);
            mac_last_o    <= tile_end;
            c_pipe        <= tile_end ? c_tile : '0;
            sram_c_we_o   <= mac_last_o;
            sram_c_addr_o <= mac_last_o ? c_pipe : '0;
        end
    end

endmodule

// File: tb/tb_gemm_ctrl.sv
// Directed bench for gemm_ctrl: cycle-exact comparison of every output
// against a loop-order reference computed with plain multiplies.
module tb_gemm_ctrl;

    localparam int AW = 12;
    localparam int SW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [SW-1:0] M_size_i = '0;
    logic [SW-1:0] K_size_i = '0;
    logic [SW-1:0] N_size_i = '0;
    logic [AW-1:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
    logic          sram_c_we_o, mac_valid_o, mac_first_o, mac_last_o;
    logic          busy_o, done_o;

    int checks   = 0;
    int failures = 0;

    gemm_ctrl #(.AddrWidth(AW), .SizeAddrWidth(SW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .M_size_i      (M_size_i),
        .K_size_i      (K_size_i),
        .N_size_i      (N_size_i),
        .sram_a_addr_o (sram_a_addr_o),
        .sram_b_addr_o (sram_b_addr_o),
        .sram_c_addr_o (sram_c_addr_o),
        .sram_c_we_o   (sram_c_we_o),
        .mac_valid_o   (mac_valid_o),
        .mac_first_o   (mac_first_o),
        .mac_last_o    (mac_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int cyc, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {22'd0, busy_o, done_o, sram_c_we_o, mac_valid_o, mac_first_o, mac_last_o,
                sram_a_addr_o, sram_b_addr_o, sram_c_addr_o};
    endfunction

    function automatic void decode(input int i, input int kk, input int nn,
                                   output int m, output int n, output int k);
        k = i % kk;
        n = (i / kk) % nn;
        m = i / (kk * nn);
    endfunction

    // Starts a GEMM at the next rising edge (edge 0) and checks cycles 1..P+4.
    task automatic run_check(input string tag, input int mm, input int kk, input int nn,
                             input bit hold, input int exp_writes);
        int p, writes, dones, m, n, k;
        bit zero;
        logic e_busy, e_done, e_we, e_v, e_f, e_l;
        logic [AW-1:0] e_a, e_b, e_c, o_c;
        p      = mm * kk * nn;
        zero   = (p == 0);
        writes = 0;
        dones  = 0;
        M_size_i = SW'(mm);
        K_size_i = SW'(kk);
        N_size_i = SW'(nn);
        start_i  = 1'b1;
        @(posedge clk_i);
        for (int c = 1; c <= (zero ? 4 : p + 4); c++) begin
            @(negedge clk_i);
            if (!hold) begin
                start_i  = 1'b0;
                M_size_i = 8'd3;
                K_size_i = 8'd7;
                N_size_i = 8'd5;
            end
            e_busy = !zero && (c <= p + 2);
            e_done = zero ? (c == 1) : (c == p + 3);
            e_a = '0; e_b = '0; e_c = '0;
            e_we = 1'b0; e_v = 1'b0; e_f = 1'b0; e_l = 1'b0;
            if (!zero && c <= p) begin
                decode(c - 1, kk, nn, m, n, k);
                e_a = AW'(m * kk + k);
                e_b = AW'(n * kk + k);
            end
            if (!zero && c >= 2 && c <= p + 1) begin
                decode(c - 2, kk, nn, m, n, k);
                e_v = 1'b1;
                e_f = (k == 0);
                e_l = (k == kk - 1);
            end
            if (!zero && c >= 3 && c <= p + 2) begin
                decode(c - 3, kk, nn, m, n, k);
                e_we = (k == kk - 1);
                e_c  = e_we ? AW'(m * nn + n) : '0;
            end
            o_c = e_we ? sram_c_addr_o : '0;
            writes += int'(sram_c_we_o);
            dones  += int'(done_o);
            check(tag, c,
                  {22'd0, busy_o, done_o, sram_c_we_o, mac_valid_o, mac_first_o, mac_last_o,
                   sram_a_addr_o, sram_b_addr_o, o_c},
                  {22'd0, e_busy, e_done, e_we, e_v, e_f, e_l, e_a, e_b, e_c});
        end
        check({tag, "_writes"}, -1, 64'(writes), 64'(exp_writes));
        check({tag, "_dones"}, -1, 64'(dones), 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        check("reset_outs", 0, all_outs(), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_check("m1k1n3", 1, 1, 3, 1'b0, 3);
        run_check("m4k16n1", 4, 16, 1, 1'b0, 4);
        run_check("m8k8n8", 8, 8, 8, 1'b0, 64);
        run_check("k0_m2n2", 2, 0, 2, 1'b0, 0);
        run_check("hold_run1", 2, 2, 2, 1'b1, 4);
        run_check("hold_run2", 2, 2, 2, 1'b0, 4);

        // Reset in the middle of a 4x4x4 run.
        M_size_i = 8'd4;
        K_size_i = 8'd4;
        N_size_i = 8'd4;
        start_i  = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check("mid_run_active", 10, {62'd0, busy_o, mac_valid_o}, 64'd3);
        rst_ni = 1'b0;
        #1;
        check("async_reset_outs", 10, all_outs(), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("held_reset_outs", 11 + c, all_outs(), 64'd0);
        end
        rst_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check("post_reset_idle", c, all_outs(), 64'd0);
        end
        run_check("after_reset", 4, 4, 4, 1'b0, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
